load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Responder to the decoder's memRead/memWrite/funct3 requests; sits between the execute stage (ALU address, rs2 data) and the data memory port.
- Converts byte/half/word accesses into word-aligned memory transactions with byte strobes.
- Masks and sign/zero-extends load data, detects misaligned and illegal accesses, and enforces a memory timeout.
- Returns a one-cycle completion pulse to the core.

Parameters:
- MAX_WAIT, 255: cycles to wait for mem_ack before aborting with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- reqValid  in  1  core presents an access this cycle
- reqReady  out  1  unit can accept (high only in IDLE)
- memRead  in  1  load request, from the decoder
- memWrite  in  1  store request, from the decoder
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from the ALU
- storeData  in  32  rs2 value; low bits significant per size
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables (0000 for reads)
- mem_ack  in  1  memory completes the request; mem_rdata valid the same cycle
- mem_rdata  in  32  read word
- respValid  out  1  one-cycle completion pulse
- loadData  out  32  extended load result, valid with respValid
- accessErr  out  1  misaligned/illegal/timeout, valid with respValid

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - mem_req, mem_we, respValid and accessErr = 0.
  - mem_addr, mem_wdata and loadData = 0.
  - mem_wstrb = 0000; wait counter = 0.
- Reset mid-transaction: the transaction is abandoned and mem_req drops the next cycle. A mem_ack arriving while in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid & (memRead|memWrite), latch funct3, addr[1:0] and the direction.
  - Legality check:
    - Illegal if memRead&memWrite, if funct3 is not in the legal set (011/110/111 for loads; anything but 000/001/010 for stores), or if misaligned (H with addr[0]=1; W with addr[1:0]!=00).
    - Illegal access: go to RESP with error; mem_req never asserts.
    - Legal access: drive mem_* registers and go to REQ.
  - reqValid with neither memRead nor memWrite is ignored.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable.
  - On mem_ack: capture the formatted load, go to RESP with error=0.
  - Else the counter increments. When the counter reaches MAX_WAIT (MAX_WAIT>0), drop mem_req and go to RESP with error=1, loadData=0.
- RESP: respValid=1 for exactly one cycle, then IDLE. The counter clears on leaving REQ.
- Latency:
  - Legal access: accept at cycle N, mem_req from N+1, respValid the cycle after mem_ack.
  - Zero-wait memory (ack in N+1) gives respValid in N+2.
  - Illegal access gives respValid in N+1.
- Store formatting:
  - B: wdata = {4{storeData[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{storeData[15:0]}}, wstrb = 0011 << addr[1:0].
  - W: wdata = storeData, wstrb = 1111.
- Load formatting:
  - Select the byte at addr[1:0] or the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- loadData = 0 for stores and for errors. loadData and accessErr hold their value until the next RESP.

Decomposition:
- Shared constants package/header alongside the existing opcode/funct3 constants:
  - FUNCT3_LB/LH/LW/LBU/LHU and SB/SH/SW encodings.
  - LSU state encodings.
  - Access-size enumeration.
- One natural combinational sub-module, lsu_align: takes funct3, addr[1:0], storeData and mem_rdata; produces wdata, wstrb, the formatted load and the misalign flag. It is shared by both paths and unit-testable alone.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80FF7F01, ack next cycle -> mem_addr 0x100, wstrb 0000, loadData 0xFFFFFF80, accessErr 0, respValid 2 cycles after accept.
- LHU at 0x102 with rdata 0x80FF7F01 -> loadData 0x000080FF; LH same -> 0xFFFF80FF.
- SB storeData 0x123456AB at 0x101 -> mem_we 1, wstrb 0010, wdata 0xABABABAB; SH at 0x102 data 0xBEEF -> wstrb 1100, wdata 0xBEEFBEEF.
- LW at 0x102, and a load with funct3 011 at 0x100 -> no mem_req, respValid next cycle, accessErr 1, loadData 0.
- MAX_WAIT=4, mem_ack held low -> mem_req high for 4 cycles then drops; respValid with accessErr 1; a later ack is ignored.
- rst_n low for one cycle during REQ -> mem_req 0 and reqReady 1 the next cycle, no respValid; a following SW at 0x200 completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 encodings,
// FSM states, access sizes and small legality helpers.
package load_store_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsuState_t;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W,
        SIZE_BAD
    } accSize_t;

    function automatic accSize_t accSize(input logic [2:0] f3);
        accSize_t s;
        unique case (f3)
            FUNCT3_LB, FUNCT3_LBU: s = SIZE_B;
            FUNCT3_LH, FUNCT3_LHU: s = SIZE_H;
            FUNCT3_LW:             s = SIZE_W;
            default:               s = SIZE_BAD;
        endcase
        return s;
    endfunction

    function automatic logic loadLegal(input logic [2:0] f3);
        return f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW,
                          FUNCT3_LBU, FUNCT3_LHU};
    endfunction

    function automatic logic storeLegal(input logic [2:0] f3);
        return f3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port bundle between the load/store unit (master)
// and the memory (slave).
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for stores, extraction/extension for loads,
// and the alignment check; purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] loadFmt,
    output logic        misaligned
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = 8'(rdata >> {addrLo, 3'b000});
    assign halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata      = storeData;
        wstrb      = 4'b0000;
        loadFmt    = rdata;
        misaligned = 1'b0;
        unique case (accSize(funct3))
            SIZE_B: begin
                wdata   = {4{storeData[7:0]}};
                wstrb   = 4'b0001 << addrLo;
                loadFmt = funct3[2] ? {24'b0, byteSel}
                                    : {{24{byteSel[7]}}, byteSel};
            end
            SIZE_H: begin
                wdata      = {2{storeData[15:0]}};
                wstrb      = 4'b0011 << addrLo;
                loadFmt    = funct3[2] ? {16'b0, halfSel}
                                       : {{16{halfSel[15]}}, halfSel};
                misaligned = addrLo[0];
            end
            SIZE_W: begin
                wstrb      = 4'b1111;
                misaligned = |addrLo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder memRead/memWrite requests into
// word-aligned strobed memory transactions with a wait timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reqValid,
    output logic               reqReady,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        storeData,
    load_store_unit_if.master  mem,
    output logic               respValid,
    output logic [31:0]        loadData,
    output logic               accessErr
);

    lsuState_t   state, stateNext;
    logic [2:0]  f3Q, f3D;
    logic [1:0]  addrLoQ, addrLoD;
    logic        weQ, weD;
    logic [31:0] waitCnt, waitCntD;
    logic        memWeQ, memWeD;
    logic [31:0] memAddrQ, memAddrD;
    logic [31:0] memWdataQ, memWdataD;
    logic [3:0]  memWstrbQ, memWstrbD;
    logic [31:0] loadQ, loadD;
    logic        errQ, errD;

    logic [2:0]  alignF3;
    logic [1:0]  alignLo;
    logic [31:0] alignWdata, alignLoad;
    logic [3:0]  alignWstrb;
    logic        misaligned;
    logic        start, illegal, timeout;

    // Incoming request is formatted in IDLE, the latched one during REQ.
    assign alignF3 = (state == IDLE) ? funct3 : f3Q;
    assign alignLo = (state == IDLE) ? addr[1:0] : addrLoQ;

    lsu_align uAlign (
        .funct3     (alignF3),
        .addrLo     (alignLo),
        .storeData  (storeData),
        .rdata      (mem.mem_rdata),
        .wdata      (alignWdata),
        .wstrb      (alignWstrb),
        .loadFmt    (alignLoad),
        .misaligned (misaligned)
    );

    assign start   = reqValid & (memRead | memWrite);
    assign illegal = (memRead & memWrite)
                   | (memRead & !loadLegal(funct3))
                   | (memWrite & !storeLegal(funct3))
                   | misaligned;
    assign timeout = (MAX_WAIT != 0) && (waitCnt == 32'(MAX_WAIT - 1));

    always_comb begin
        stateNext = state;
        f3D       = f3Q;
        addrLoD   = addrLoQ;
        weD       = weQ;
        waitCntD  = waitCnt;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        memWstrbD = memWstrbQ;
        loadD     = loadQ;
        errD      = errQ;
        unique case (state)
            IDLE: begin
                if (start) begin
                    f3D     = funct3;
                    addrLoD = addr[1:0];
                    weD     = memWrite;
                    if (illegal) begin
                        stateNext = RESP;
                        loadD     = '0;
                        errD      = 1'b1;
                    end else begin
                        stateNext = REQ;
                        memAddrD  = {addr[31:2], 2'b00};
                        memWeD    = memWrite;
                        memWdataD = memWrite ? alignWdata : '0;
                        memWstrbD = memWrite ? alignWstrb : 4'b0000;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    stateNext = RESP;
                    loadD     = weQ ? '0 : alignLoad;
                    errD      = 1'b0;
                    waitCntD  = '0;
                end else if (timeout) begin
                    stateNext = RESP;
                    loadD     = '0;
                    errD      = 1'b1;
                    waitCntD  = '0;
                end else begin
                    waitCntD = waitCnt + 32'd1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            f3Q       <= '0;
            addrLoQ   <= '0;
            weQ       <= 1'b0;
            waitCnt   <= '0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            memWstrbQ <= '0;
            loadQ     <= '0;
            errQ      <= 1'b0;
        end else begin
            state     <= stateNext;
            f3Q       <= f3D;
            addrLoQ   <= addrLoD;
            weQ       <= weD;
            waitCnt   <= waitCntD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            memWstrbQ <= memWstrbD;
            loadQ     <= loadD;
            errQ      <= errD;
        end
    end

    assign reqReady      = (state == IDLE);
    assign respValid     = (state == RESP);
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = memWeQ;
    assign mem.mem_addr  = memAddrQ;
    assign mem.mem_wdata = memWdataQ;
    assign mem.mem_wstrb = memWstrbQ;
    assign loadData      = loadQ;
    assign accessErr     = errQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven
// through a response scoreboard, plus timeout and reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] storeData = '0;
    logic        respValid;
    logic [31:0] loadData;
    logic        accessErr;

    load_store_unit_if memIf ();

    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .mem       (memIf),
        .respValid (respValid),
        .loadData  (loadData),
        .accessErr (accessErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ackDly;
        logic        legal;
        logic [31:0] eAddr;
        logic        eWe;
        logic [3:0]  eStrb;
        logic [31:0] eWdata;
        logic [31:0] eLoad;
        logic        eErr;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] load;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitResp();
        int n = 0;
        exp_t e;
        while (!respValid && n < 16) begin
            tick();
            n++;
        end
        chk("respSeen", 32'(respValid), 32'd1);
        if (!respValid) begin
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sbEmpty actual=respValid required=none");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".lat"}, cyc, e.due);
        chk({e.name, ".load"}, loadData, e.load);
        chk({e.name, ".err"}, 32'(accessErr), 32'(e.err));
        tick();
        chk({e.name, ".pulse"}, 32'(respValid), 32'd0);
        chk({e.name, ".ready"}, 32'(reqReady), 32'd1);
        chk({e.name, ".hold"}, loadData, e.load);
    endtask

    task automatic runVec(input vec_t v);
        int acc;
        memRead   = v.rd;
        memWrite  = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        storeData = v.sd;
        reqValid  = 1'b1;
        tick();
        reqValid = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        storeData = 32'h5A5A_0F0F;
        acc = cyc;
        sb.push_back('{v.name, v.eLoad, v.eErr,
                       v.legal ? acc + v.ackDly + 1 : acc});
        if (v.legal) begin
            chk({v.name, ".req"}, 32'(memIf.mem_req), 32'd1);
            chk({v.name, ".addr"}, memIf.mem_addr, v.eAddr);
            chk({v.name, ".we"}, 32'(memIf.mem_we), 32'(v.eWe));
            chk({v.name, ".strb"}, 32'(memIf.mem_wstrb), 32'(v.eStrb));
            if (v.wr) chk({v.name, ".wdata"}, memIf.mem_wdata, v.eWdata);
            for (int k = 0; k < v.ackDly; k++) begin
                tick();
                chk({v.name, ".held"}, 32'(memIf.mem_req), 32'd1);
                chk({v.name, ".addrHeld"}, memIf.mem_addr, v.eAddr);
            end
            memIf.mem_ack   = 1'b1;
            memIf.mem_rdata = v.rdata;
            tick();
            memIf.mem_ack   = 1'b0;
            memIf.mem_rdata = $urandom;
        end else begin
            chk({v.name, ".noReq"}, 32'(memIf.mem_req), 32'd0);
        end
        waitResp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        vec_t sw200;
        vecs = '{
          '{"lb103", 1, 0, 3'b000, 32'h103, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'hFFFFFF80, 0},
          '{"lhu102", 1, 0, 3'b101, 32'h102, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'h000080FF, 0},
          '{"lh102", 1, 0, 3'b001, 32'h102, 0, 32'h80FF7F01, 1, 1,
            32'h100, 0, 4'h0, 0, 32'hFFFF80FF, 0},
          '{"lbu100", 1, 0, 3'b100, 32'h100, 0, 32'h80FF7F01, 2, 1,
            32'h100, 0, 4'h0, 0, 32'h00000001, 0},
          '{"lb101", 1, 0, 3'b000, 32'h101, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'h0000007F, 0},
          '{"lb102", 1, 0, 3'b000, 32'h102, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'hFFFFFFFF, 0},
          '{"lbu102", 1, 0, 3'b100, 32'h102, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'h000000FF, 0},
          '{"lh100", 1, 0, 3'b001, 32'h100, 0, 32'h80FF7F01, 0, 1,
            32'h100, 0, 4'h0, 0, 32'h00007F01, 0},
          '{"lw100", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 1,
            32'h100, 0, 4'h0, 0, 32'hDEADBEEF, 0},
          '{"lw102", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"sb101", 0, 1, 3'b000, 32'h101, 32'h123456AB, 32'hFFFFFFFF,
            0, 1, 32'h100, 1, 4'b0010, 32'hABABABAB, 0, 0},
          '{"sh102", 0, 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0, 1,
            32'h100, 1, 4'b1100, 32'hBEEFBEEF, 0, 0},
          '{"sw204", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 2, 1,
            32'h204, 1, 4'b1111, 32'hCAFEF00D, 0, 0},
          '{"sb403", 0, 1, 3'b000, 32'h403, 32'h00000055, 0, 1, 1,
            32'h400, 1, 4'b1000, 32'h55555555, 0, 0},
          '{"ld011", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"sh101", 0, 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"sw202", 0, 1, 3'b010, 32'h202, 32'h1234, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"st100", 0, 1, 3'b100, 32'h100, 32'h1234, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"rdwr", 1, 1, 3'b010, 32'h100, 0, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1},
          '{"lhu103", 1, 0, 3'b101, 32'h103, 0, 0, 0, 0,
            0, 0, 4'h0, 0, 0, 1}
        };
        sw200 = '{"sw200", 0, 1, 3'b010, 32'h200, 32'h89ABCDEF, 0, 0, 1,
                  32'h200, 1, 4'b1111, 32'h89ABCDEF, 0, 0};

        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = '0;
        tick();
        tick();
        chk("rst.ready", 32'(reqReady), 32'd1);
        chk("rst.req", 32'(memIf.mem_req), 32'd0);
        chk("rst.we", 32'(memIf.mem_we), 32'd0);
        chk("rst.addr", memIf.mem_addr, 32'd0);
        chk("rst.wdata", memIf.mem_wdata, 32'd0);
        chk("rst.strb", 32'(memIf.mem_wstrb), 32'd0);
        chk("rst.resp", 32'(respValid), 32'd0);
        chk("rst.err", 32'(accessErr), 32'd0);
        chk("rst.load", loadData, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) runVec(vecs[i]);

        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        chk("nop.ready", 32'(reqReady), 32'd1);
        chk("nop.req", 32'(memIf.mem_req), 32'd0);
        tick();
        chk("nop.resp", 32'(respValid), 32'd0);

        memRead  = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h300;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        memRead  = 1'b0;
        acc = cyc;
        sb.push_back('{"tmo", 32'd0, 1'b1, acc + 4});
        chk("tmo.addr", memIf.mem_addr, 32'h300);
        n = 0;
        while (memIf.mem_req && n < 10) begin
            n++;
            tick();
        end
        chk("tmo.reqCycles", n, 32'd4);
        waitResp();
        memIf.mem_ack = 1'b1;
        tick();
        memIf.mem_ack = 1'b0;
        chk("late.resp", 32'(respValid), 32'd0);
        chk("late.ready", 32'(reqReady), 32'd1);
        tick();
        chk("late.resp2", 32'(respValid), 32'd0);

        memRead  = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h100;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        memRead  = 1'b0;
        chk("mid.req", 32'(memIf.mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid.reqDrop", 32'(memIf.mem_req), 32'd0);
        chk("mid.ready", 32'(reqReady), 32'd1);
        chk("mid.resp", 32'(respValid), 32'd0);
        chk("mid.err", 32'(accessErr), 32'd0);
        tick();
        chk("mid.resp2", 32'(respValid), 32'd0);
        runVec(sw200);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sbLeft actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
